// File: rtl/bcd_scan_pkg.sv
// Shared constants for the sign-plus-4-digit BCD scan display: positions,
// sign nibble codes and active-low seven-segment glyphs {g,f,e,d,c,b,a}.
package bcd_scan_pkg;

  localparam int NUM_POS = 5;

  localparam logic [3:0] SIGN_POS = 4'd0;
  localparam logic [3:0] SIGN_NEG = 4'd5;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit nibble to glyph; anything outside 0..9 renders as 'E'.
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = SEG_0;
      4'd1:    digit_seg = SEG_1;
      4'd2:    digit_seg = SEG_2;
      4'd3:    digit_seg = SEG_3;
      4'd4:    digit_seg = SEG_4;
      4'd5:    digit_seg = SEG_5;
      4'd6:    digit_seg = SEG_6;
      4'd7:    digit_seg = SEG_7;
      4'd8:    digit_seg = SEG_8;
      4'd9:    digit_seg = SEG_9;
      default: digit_seg = SEG_E;
    endcase
  endfunction

endpackage

// File: rtl/bcd_scan_display_glyph.sv
// seg7_glyph: combinational nibble-to-segment decoder for one display position,
// handling the sign position (blank / minus / E) and forced blanking.
module seg7_glyph
  import bcd_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       is_sign_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else if (is_sign_i) begin
      if (nib_i == SIGN_POS)      seg_o = SEG_BLANK;
      else if (nib_i == SIGN_NEG) seg_o = SEG_MINUS;
      else                        seg_o = SEG_E;
    end else begin
      seg_o = digit_seg(nib_i);
    end
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Five-position multiplexed seven-segment driver with frame-aligned double
// buffering. Define BCD_SCAN_LZB_EN to enable leading-zero blanking.
module bcd_scan_display
  import bcd_scan_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [19:0] bcd_i,
  input  logic        load_i,
  output logic [4:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        frame_o
);

  localparam int             PW   = $clog2(DIV);
  localparam logic [PW-1:0]  PMAX = PW'(DIV - 1);
  localparam logic [2:0]     LAST = 3'(NUM_POS - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [19:0]   staging_q, staging_d;
  logic [19:0]   disp_q, disp_d;
  logic          pending_q, pending_d;
  logic          frame_q, frame_d;
  logic [4:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          tick, wrap;
  logic [3:0]    nib;
  logic          is_sign, blank;
  logic [6:0]    glyph;

  always_comb begin
    tick   = (pcnt_q == PMAX);
    wrap   = tick && (idx_q == LAST);
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    idx_d  = idx_q;
    if (tick) idx_d = (idx_q == LAST) ? 3'd0 : idx_q + 3'd1;
  end

  // A load coinciding with the wrap bypasses staging so it is not lost.
  always_comb begin
    staging_d = staging_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    frame_d   = 1'b0;
    if (wrap && load_i) begin
      disp_d    = bcd_i;
      pending_d = 1'b0;
      frame_d   = 1'b1;
    end else begin
      if (load_i) begin
        staging_d = bcd_i;
        pending_d = 1'b1;
      end
      if (wrap && pending_q) begin
        disp_d    = staging_q;
        pending_d = 1'b0;
        frame_d   = 1'b1;
      end
    end
  end

  // Glyph is evaluated on the next-state index and buffer so the output
  // register shows the new frame from its first digit.
  always_comb begin
    nib     = 4'd0;
    is_sign = (idx_d == LAST);
    case (idx_d)
      3'd0:    nib = disp_d[3:0];
      3'd1:    nib = disp_d[7:4];
      3'd2:    nib = disp_d[11:8];
      3'd3:    nib = disp_d[15:12];
      3'd4:    nib = disp_d[19:16];
      default: nib = 4'd0;
    endcase
`ifdef BCD_SCAN_LZB_EN
    blank = ((idx_d == 3'd3) && (disp_d[15:12] == 4'd0)) ||
            ((idx_d == 3'd2) && (disp_d[15:8]  == 8'd0)) ||
            ((idx_d == 3'd1) && (disp_d[15:4]  == 12'd0));
`else
    blank = 1'b0;
`endif
  end

  seg7_glyph u_glyph (
    .nib_i     (nib),
    .is_sign_i (is_sign),
    .blank_i   (blank),
    .seg_o     (glyph)
  );

  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      an_d  = ~(5'b00001 << idx_d);
      seg_d = glyph;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pcnt_q    <= '0;
      idx_q     <= 3'd0;
      staging_q <= 20'd0;
      disp_q    <= 20'd0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      an_q      <= 5'b11111;
      seg_q     <= 7'h7F;
    end else begin
      pcnt_q    <= pcnt_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display (DIV=4): cycle-accurate reference model derived
// from elapsed-cycle arithmetic, a glyph table, directed corners and random loads.
module tb_bcd_scan_display;

  localparam int DIV   = 4;
  localparam int FRAME = 5 * DIV;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000, SM = 7'b0111111, SE = 7'b0000110;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] bcd;
  logic        load;
  logic [4:0]  an;
  logic [6:0]  seg;
  logic        frame;

  int checks = 0;
  int errors = 0;
  int frames = 0;

  bcd_scan_display #(.DIV(DIV)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bcd_i   (bcd),
    .load_i  (load),
    .an_o    (an),
    .seg_o   (seg),
    .frame_o (frame)
  );

  always #5 clk = ~clk;

  // Reference model state: edges elapsed since reset release, buffers.
  int          m_t;
  logic [19:0] m_stg, m_disp;
  bit          m_pend;
  logic [4:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_frame;
  logic [6:0]  dig [10];

  function automatic logic [6:0] ref_glyph(input logic [19:0] d, input int p);
    logic [3:0] n;
    bit zero;
    n = d[4*p +: 4];
    if (p == 4) return (n == 4'd0) ? SB : (n == 4'd5) ? SM : SE;
    if (n > 4'd9) return SE;
`ifdef BCD_SCAN_LZB_EN
    if (p >= 1) begin
      zero = 1'b1;
      for (int k = p; k <= 3; k++) if (d[4*k +: 4] != 4'd0) zero = 1'b0;
      if (zero) return SB;
    end
`else
    zero = 1'b0;
`endif
    return dig[n];
  endfunction

  task automatic model_edge();
    bit tick, wrap;
    int pos;
    if (!rst_n) begin
      m_t = 0; m_stg = '0; m_disp = '0; m_pend = 0;
      e_an = 5'b11111; e_seg = 7'h7F; e_frame = 1'b0;
    end else begin
      tick = ((m_t % DIV) == DIV - 1);
      pos  = (m_t / DIV) % 5;
      wrap = tick && (pos == 4);
      e_frame = 1'b0;
      if (wrap && load) begin
        m_disp = bcd; m_pend = 0; e_frame = 1'b1;
      end else begin
        if (load) begin m_stg = bcd; m_pend = 1; end
        if (wrap && m_pend) begin m_disp = m_stg; m_pend = 0; e_frame = 1'b1; end
      end
      if (tick) begin
        e_an  = ~(5'b00001 << ((pos + 1) % 5));
        e_seg = ref_glyph(m_disp, (pos + 1) % 5);
      end
      m_t++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_an", {27'd0, an}, {27'd0, e_an});
    chk("model_seg", {25'd0, seg}, {25'd0, e_seg});
    chk("model_frame", {31'd0, frame}, {31'd0, e_frame});
    if (frame) frames++;
  endtask

  // Advance until the next edge is number r within the refresh period.
  task automatic align(input int r);
    for (int i = 0; i < FRAME && (m_t % FRAME) != r; i++) cyc();
  endtask

  task automatic pulse_load(input logic [19:0] v);
    bcd = v; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  typedef struct {
    logic [19:0]     bcd;
    logic [4:0][6:0] seg;
  } vec_t;

  vec_t tv [5];

  initial begin
    bit got;
    dig = '{S0, S1, S2, S3, S4, 7'b0010010, 7'b0000010, S7, 7'b0000000, S9};
    tv[0] = '{bcd: 20'h51234, seg: {SM, S1, S2, S3, S4}};
    tv[1] = '{bcd: 20'h09999, seg: {SB, S9, S9, S9, S9}};
`ifdef BCD_SCAN_LZB_EN
    tv[2] = '{bcd: 20'h30A07, seg: {SE, SB, SE, S0, S7}};
    tv[3] = '{bcd: 20'h00000, seg: {SB, SB, SB, SB, S0}};
    tv[4] = '{bcd: 20'h50010, seg: {SM, SB, SB, S1, S0}};
`else
    tv[2] = '{bcd: 20'h30A07, seg: {SE, S0, SE, S0, S7}};
    tv[3] = '{bcd: 20'h00000, seg: {SB, S0, S0, S0, S0}};
    tv[4] = '{bcd: 20'h50010, seg: {SM, S0, S0, S1, S0}};
`endif

    rst_n = 1'b0; load = 1'b0; bcd = '0;
    cyc(); cyc();
    chk("reset_an", {27'd0, an}, 32'h1F);
    chk("reset_seg", {25'd0, seg}, 32'h7F);
    chk("reset_frame", {31'd0, frame}, 32'd0);
    rst_n = 1'b1;

    // Dark until the first tick, then the idle scan.
    repeat (DIV - 1) cyc();
    chk("dark_before_tick", {27'd0, an}, 32'h1F);
    repeat (2 * FRAME) cyc();

    // Glyph table: load mid-frame, then read a full frame back.
    foreach (tv[v]) begin
      align(6);
      pulse_load(tv[v].bcd);
      got = 0;
      for (int i = 0; i < FRAME + 2 && !got; i++) begin
        cyc();
        got = frame;
      end
      chk("table_frame_seen", {31'd0, got}, 32'd1);
      for (int p = 0; p < 5; p++) begin
        chk("table_an", {27'd0, an}, {27'd0, ~(5'b00001 << p)});
        chk("table_seg", {25'd0, seg}, {25'd0, tv[v].seg[p]});
        repeat (DIV) cyc();
      end
    end

    // Load exactly on the wrap edge goes straight to the display.
    align(FRAME - 1);
    pulse_load(20'h09999);
    chk("wrap_load_frame", {31'd0, frame}, 32'd1);
    chk("wrap_load_seg", {25'd0, seg}, {25'd0, S9});

    // Two loads before one wrap: last wins, single frame pulse.
    align(3);
    frames = 0;
    pulse_load(20'h01111);
    repeat (3) cyc();
    pulse_load(20'h02222);
    repeat (FRAME + DIV) cyc();
    chk("two_load_frames", frames, 32'd1);
    align(FRAME - 1);
    cyc();
    chk("two_load_seg", {25'd0, seg}, {25'd0, S2});

    // Random loads, nibbles include illegal codes.
    for (int i = 0; i < 600; i++) begin
      logic [19:0] r;
      int s;
      for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'($urandom_range(0, 11));
      s = $urandom_range(0, 3);
      r[19:16] = (s == 0) ? 4'd0 : (s == 1) ? 4'd5 : 4'($urandom_range(0, 15));
      bcd  = r;
      load = ($urandom_range(0, 7) == 0);
      cyc();
    end
    load = 1'b0;

    // Reset mid-scan with a load pending discards it.
    align(5);
    pulse_load(20'h54321);
    repeat (2) cyc();
    rst_n = 1'b0;
    cyc();
    chk("midrst_an", {27'd0, an}, 32'h1F);
    chk("midrst_seg", {25'd0, seg}, 32'h7F);
    rst_n = 1'b1;
    frames = 0;
    repeat (3 * FRAME) cyc();
    chk("midrst_no_frame", frames, 32'd0);
    align(FRAME - 1);
    cyc();
    chk("midrst_ones", {25'd0, seg}, {25'd0, S0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
